proto_field_lookup: RTL and testbench
=====================================

PROTO_FIELD_LOOKUP -- requirements
Module: proto_field_lookup

Interface
REQ-001 Parameter DEPTH, default 3, maximum nesting levels of the message path stack.
REQ-002 Parameter NUM_MSGS, default 3, number of message entries in the dependency/field tables.
REQ-003 Parameter MAX_FIELDS, default 4, field-metadata slots per message.
REQ-004 Parameter ID_W, default 8, identifier width; META_W, default 22, field-metadata width, with the identifier in bits [ID_W-1:0].
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cfg_dep_we  in  1  write dependency entry cfg_msg_idx with cfg_dep_data.
REQ-008 cfg_fld_we  in  1  write field slot (cfg_msg_idx, cfg_fld_slot) with cfg_fld_data.
REQ-009 cfg_msg_idx  in  clog2(NUM_MSGS); cfg_fld_slot  in  clog2(MAX_FIELDS); cfg_dep_data  in  DEPTH*ID_W, level 0 in the LSBs; cfg_fld_data  in  META_W.
REQ-010 nest_push  in  1, nest_pop  in  1, nest_id  in  ID_W  path stack control; nest_depth  out  clog2(DEPTH+1)  current depth.
REQ-011 req_valid  in  1, req_ready  out  1, req_field_id  in  ID_W  lookup request.
REQ-012 rsp_valid  out  1, rsp_ready  in  1, rsp_hit  out  1, rsp_msg_idx  out  clog2(NUM_MSGS), rsp_meta  out  META_W  lookup response.
REQ-013 err_overflow  out  1, err_underflow  out  1  single-cycle error pulses.

Function
REQ-014 Path stack: push writes nest_id at level nest_depth, depth+1; pop clears top level to 0, depth-1; levels at or above depth read as 0.
REQ-015 Push at depth==DEPTH is ignored and pulses err_overflow; pop at depth 0 is ignored and pulses err_underflow.
REQ-016 Simultaneous push and pop: depth>0 replaces the top identifier, depth unchanged; depth 0 acts as a plain push.
REQ-017 FSM states IDLE, MSG_SCAN, FLD_SCAN, RESP; req_ready=1 only in IDLE.
REQ-018 On accept (req_valid & req_ready) latch req_field_id and the full stack vector snapshot; enter MSG_SCAN at entry 0; later push/pop do not affect the lookup in flight.
REQ-019 MSG_SCAN examines one entry per cycle; match when the entry equals the snapshot exactly; first (lowest index) match goes to FLD_SCAN slot 0; no match after entry NUM_MSGS-1 goes to RESP with rsp_hit=0.
REQ-020 FLD_SCAN examines one slot per cycle; hit when slot identifier equals the latched ID and is nonzero; hit goes to RESP with rsp_hit=1, rsp_meta=slot data; slot MAX_FIELDS-1 without hit goes to RESP with rsp_hit=0.
REQ-021 Latency: accept at edge T, hit at message m slot s gives rsp_valid from cycle T+3+m+s; message miss gives rsp_valid at T+1+NUM_MSGS.
REQ-022 RESP holds rsp_valid and all rsp_* stable until rsp_valid & rsp_ready, then returns to IDLE; next request accepted no earlier than the following cycle.
REQ-023 On miss rsp_meta=0; rsp_msg_idx = matched index, or 0 on message miss.
REQ-024 Config writes complete in one cycle, accepted in any state; a write to an entry being scanned is visible from the next cycle.

Reset
REQ-025 rst_n low asynchronously forces IDLE, nest_depth=0, stack=0, tables=0, req_ready=0 during reset and 1 the first cycle after release, rsp_valid=0, rsp_hit=0, rsp_meta=0, rsp_msg_idx=0, err_*=0.
REQ-026 Reset mid-lookup discards the lookup with no response.

Configuration
REQ-027 Macro PROTO_LOOKUP_MISS_CNT_EN: when defined, output miss_cnt (16 bits, reset 0) increments on each completed rsp_hit=0 handshake, saturating at 16'hFFFF; when undefined, the port and counter do not exist and all other behaviour is identical.

Verification
REQ-028 Load deps {00,00,AA},{00,BB,AA},{CC,BB,AA}; push AA,BB; request 02; entry 1 slot 1 = id 02 -> rsp_hit=1, rsp_msg_idx=1, rsp_meta=entry, rsp_valid at T+5.
REQ-029 Same tables, path AA only, request 09 -> rsp_hit=0, rsp_meta=0, rsp_valid at T+6.
REQ-030 Push AA,BB,CC then push DD -> err_overflow one cycle, depth stays 3; four pops -> err_underflow on fourth, depth 0.
REQ-031 rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0; push/pop during lookup do not change result.
REQ-032 Assert rst_n low during FLD_SCAN -> outputs at reset values immediately, no rsp_valid after release.
REQ-033 With PROTO_LOOKUP_MISS_CNT_EN, three misses and one hit -> miss_cnt=3.

Source files
------------

// File: rtl/proto_field_lookup_if.sv
// Lookup request/response bundle for proto_field_lookup.
// slave: the lookup engine; master: the requester.
interface proto_field_lookup_if #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned META_W = 22,
  parameter int unsigned MSG_W  = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_field_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [MSG_W-1:0]  rsp_msg_idx;
  logic [META_W-1:0] rsp_meta;

  modport master (
    output req_valid, req_field_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_msg_idx, rsp_meta
  );

  modport slave (
    input  req_valid, req_field_id, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_msg_idx, rsp_meta
  );
endinterface

// File: rtl/proto_field_lookup.sv
// Protobuf-style field metadata lookup keyed by the current message nesting path.
// A path stack tracks nesting; a request snapshots the path, scans the dependency
// table for the matching message, then scans that message's field slots.
// Optional: define PROTO_LOOKUP_MISS_CNT_EN to add the saturating miss_cnt output.
module proto_field_lookup #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned NUM_MSGS   = 3,
  parameter int unsigned MAX_FIELDS = 4,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned META_W     = 22,
  localparam int unsigned MSG_W     = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
  localparam int unsigned SLOT_W    = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1,
  localparam int unsigned DEP_W     = $clog2(DEPTH + 1),
  localparam int unsigned PATH_W    = DEPTH * ID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_dep_we,
  input  logic              cfg_fld_we,
  input  logic [MSG_W-1:0]  cfg_msg_idx,
  input  logic [SLOT_W-1:0] cfg_fld_slot,
  input  logic [PATH_W-1:0] cfg_dep_data,
  input  logic [META_W-1:0] cfg_fld_data,
  input  logic              nest_push,
  input  logic              nest_pop,
  input  logic [ID_W-1:0]   nest_id,
  output logic [DEP_W-1:0]  nest_depth,
  proto_field_lookup_if.slave bus,
  output logic              err_overflow,
  output logic              err_underflow
`ifdef PROTO_LOOKUP_MISS_CNT_EN
  ,
  output logic [15:0]       miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, MSG_SCAN, FLD_SCAN, RESP} state_t;

  state_t                        state, state_d;
  logic [DEPTH-1:0][ID_W-1:0]    stack;
  logic [PATH_W-1:0]             dep_tbl [NUM_MSGS];
  logic [META_W-1:0]             fld_tbl [NUM_MSGS][MAX_FIELDS];
  logic [PATH_W-1:0]             snap;
  logic [ID_W-1:0]               lat_id;
  logic [MSG_W-1:0]              scan_msg, scan_msg_d;
  logic [SLOT_W-1:0]             scan_slot, scan_slot_d;
  logic                          req_ready_q, req_ready_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          rsp_hit_q, rsp_hit_d;
  logic [MSG_W-1:0]              rsp_idx_q, rsp_idx_d;
  logic [META_W-1:0]             rsp_meta_q, rsp_meta_d;
  logic                          accept;
  logic [META_W-1:0]             slot_data;
  logic [DEP_W-1:0]              top;

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_hit     = rsp_hit_q;
  assign bus.rsp_msg_idx = rsp_idx_q;
  assign bus.rsp_meta    = rsp_meta_q;
  assign slot_data       = fld_tbl[scan_msg][scan_slot];
  assign top             = nest_depth - DEP_W'(1);

  // Path stack: push/pop/replace with overflow and underflow pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack         <= '0;
      nest_depth    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      if (nest_push && nest_pop && nest_depth != '0) begin
        stack[top] <= nest_id;
      end else if (nest_push) begin
        if (nest_depth == DEP_W'(DEPTH)) begin
          err_overflow <= 1'b1;
        end else begin
          stack[nest_depth] <= nest_id;
          nest_depth        <= nest_depth + DEP_W'(1);
        end
      end else if (nest_pop) begin
        if (nest_depth == '0) begin
          err_underflow <= 1'b1;
        end else begin
          stack[top] <= '0;
          nest_depth <= top;
        end
      end
    end
  end

  // Configuration tables: single-cycle writes, out-of-range indices ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < int'(NUM_MSGS); m++) begin
        dep_tbl[m] <= '0;
        for (int s = 0; s < int'(MAX_FIELDS); s++) fld_tbl[m][s] <= '0;
      end
    end else begin
      if (cfg_dep_we && 32'(cfg_msg_idx) < NUM_MSGS)
        dep_tbl[cfg_msg_idx] <= cfg_dep_data;
      if (cfg_fld_we && 32'(cfg_msg_idx) < NUM_MSGS && 32'(cfg_fld_slot) < MAX_FIELDS)
        fld_tbl[cfg_msg_idx][cfg_fld_slot] <= cfg_fld_data;
    end
  end

  // Request capture: freeze field id and the full path at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_id <= '0;
      snap   <= '0;
    end else if (accept) begin
      lat_id <= bus.req_field_id;
      snap   <= stack;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      scan_msg    <= '0;
      scan_slot   <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_meta_q  <= '0;
    end else begin
      state       <= state_d;
      scan_msg    <= scan_msg_d;
      scan_slot   <= scan_slot_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_meta_q  <= rsp_meta_d;
    end
  end

  // Next state: one message entry or one field slot examined per cycle.
  always_comb begin
    state_d     = state;
    scan_msg_d  = scan_msg;
    scan_slot_d = scan_slot;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_meta_d  = rsp_meta_q;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          accept      = 1'b1;
          req_ready_d = 1'b0;
          scan_msg_d  = '0;
          state_d     = MSG_SCAN;
        end
      end
      MSG_SCAN: begin
        if (dep_tbl[scan_msg] == snap) begin
          scan_slot_d = '0;
          state_d     = FLD_SCAN;
        end else if (scan_msg == MSG_W'(NUM_MSGS - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = '0;
          rsp_meta_d  = '0;
          state_d     = RESP;
        end else begin
          scan_msg_d = scan_msg + MSG_W'(1);
        end
      end
      FLD_SCAN: begin
        if (slot_data[ID_W-1:0] == lat_id && lat_id != '0) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_idx_d   = scan_msg;
          rsp_meta_d  = slot_data;
          state_d     = RESP;
        end else if (scan_slot == SLOT_W'(MAX_FIELDS - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = scan_msg;
          rsp_meta_d  = '0;
          state_d     = RESP;
        end else begin
          scan_slot_d = scan_slot + SLOT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = '0;
          rsp_meta_d  = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PROTO_LOOKUP_MISS_CNT_EN
  // Saturating count of completed miss responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= 16'h0000;
    end else if (rsp_valid_q && bus.rsp_ready && !rsp_hit_q && miss_cnt != 16'hFFFF) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_proto_field_lookup.sv
// Bench for proto_field_lookup: directed vector table, hand sequences for
// overflow/underflow, stalls and mid-lookup reset, then randomized lookups
// checked against a path/table model.
module tb_proto_field_lookup;
  localparam int DEPTH      = 3;
  localparam int NUM_MSGS   = 3;
  localparam int MAX_FIELDS = 4;

  logic        clk;
  logic        rst_n;
  logic        cfg_dep_we, cfg_fld_we;
  logic [1:0]  cfg_msg_idx, cfg_fld_slot;
  logic [23:0] cfg_dep_data;
  logic [21:0] cfg_fld_data;
  logic        nest_push, nest_pop;
  logic [7:0]  nest_id;
  logic [1:0]  nest_depth;
  logic        err_overflow, err_underflow;
`ifdef PROTO_LOOKUP_MISS_CNT_EN
  logic [15:0] miss_cnt;
`endif

  proto_field_lookup_if #(.ID_W(8), .META_W(22), .MSG_W(2)) bus ();

  proto_field_lookup dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_dep_we    (cfg_dep_we),
    .cfg_fld_we    (cfg_fld_we),
    .cfg_msg_idx   (cfg_msg_idx),
    .cfg_fld_slot  (cfg_fld_slot),
    .cfg_dep_data  (cfg_dep_data),
    .cfg_fld_data  (cfg_fld_data),
    .nest_push     (nest_push),
    .nest_pop      (nest_pop),
    .nest_id       (nest_id),
    .nest_depth    (nest_depth),
    .bus           (bus.slave),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef PROTO_LOOKUP_MISS_CNT_EN
    ,
    .miss_cnt      (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] dep_m [NUM_MSGS];
  logic [21:0] fld_m [NUM_MSGS][MAX_FIELDS];
  logic [7:0]  stk [$];
  int          m_miss;

  typedef struct {
    int         np;
    logic [7:0] p0, p1, p2;
    logic [7:0] id;
    bit         hit;
    logic [1:0] idx;
    logic [21:0] meta;
    int         lat;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    stk.delete();
    m_miss = 0;
    for (int m = 0; m < NUM_MSGS; m++) begin
      dep_m[m] = '0;
      for (int s = 0; s < MAX_FIELDS; s++) fld_m[m][s] = '0;
    end
  endtask

  // Reference lookup: first message whose path equals the current stack, then
  // first slot with a nonzero matching id. Latency counted in clock edges after accept.
  function automatic void m_lookup(input logic [7:0] id, output bit hit, output logic [1:0] idx,
                                   output logic [21:0] meta, output int lat);
    logic [23:0] path;
    path = '0;
    for (int i = 0; i < stk.size(); i++) path[i*8 +: 8] = stk[i];
    hit = 0; idx = '0; meta = '0; lat = NUM_MSGS;
    for (int m = 0; m < NUM_MSGS; m++) begin
      if (dep_m[m] == path) begin
        idx = 2'(m);
        lat = 2 + m + MAX_FIELDS - 1;
        for (int s = 0; s < MAX_FIELDS; s++) begin
          if (id != 8'h00 && fld_m[m][s][7:0] == id) begin
            hit = 1; meta = fld_m[m][s]; lat = 2 + m + s;
            break;
          end
        end
        break;
      end
    end
  endfunction

  task automatic cfg_dep(input int m, input logic [23:0] d);
    @(negedge clk);
    cfg_dep_we = 1'b1; cfg_msg_idx = 2'(m); cfg_dep_data = d;
    @(posedge clk); #1;
    cfg_dep_we = 1'b0;
    dep_m[m] = d;
  endtask

  task automatic cfg_fld(input int m, input int s, input logic [21:0] d);
    @(negedge clk);
    cfg_fld_we = 1'b1; cfg_msg_idx = 2'(m); cfg_fld_slot = 2'(s); cfg_fld_data = d;
    @(posedge clk); #1;
    cfg_fld_we = 1'b0;
    fld_m[m][s] = d;
  endtask

  task automatic load_tables();
    cfg_dep(0, 24'h0000AA);
    cfg_dep(1, 24'h00BBAA);
    cfg_dep(2, 24'hCCBBAA);
    cfg_fld(0, 0, 22'h000101);
    cfg_fld(0, 1, 22'h3C0000);
    cfg_fld(0, 2, 22'h2F0007);
    cfg_fld(1, 0, 22'h03AB05);
    cfg_fld(1, 1, 22'h123402);
    cfg_fld(2, 0, 22'h155509);
    cfg_fld(2, 3, 22'h3FFF02);
  endtask

  task automatic nest_op(input bit psh, input bit pp, input logic [7:0] id);
    bit e_ov, e_un;
    int sz;
    sz = stk.size(); e_ov = 0; e_un = 0;
    if (psh && pp && sz > 0) stk[sz-1] = id;
    else if (psh) begin
      if (sz < DEPTH) stk.push_back(id); else e_ov = 1;
    end else if (pp) begin
      if (sz > 0) void'(stk.pop_back()); else e_un = 1;
    end
    @(negedge clk);
    nest_push = psh; nest_pop = pp; nest_id = id;
    @(posedge clk); #1;
    nest_push = 1'b0; nest_pop = 1'b0;
    chk("nest_depth", 64'(nest_depth), 64'(stk.size()));
    chk("err_overflow", 64'(err_overflow), 64'(e_ov));
    chk("err_underflow", 64'(err_underflow), 64'(e_un));
  endtask

  task automatic set_path(input int np, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    while (stk.size() > 0) nest_op(0, 1, 8'h00);
    if (np > 0) nest_op(1, 0, p0);
    if (np > 1) nest_op(1, 0, p1);
    if (np > 2) nest_op(1, 0, p2);
  endtask

  // Issue one request, check latency and response, stall hold cycles, then handshake.
  task automatic do_lookup(input logic [7:0] id, input bit e_hit, input logic [1:0] e_idx,
                           input logic [21:0] e_meta, input int e_lat, input int hold, input bit disturb);
    int  n;
    bit  got;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_field_id = id;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_field_id = 8'($urandom);
    if (disturb) begin nest_push = 1'b1; nest_id = 8'hCC; end
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(posedge clk); n++; #1;
      if (disturb && n == 1) begin
        nest_push = 1'b0;
        if (stk.size() < DEPTH) stk.push_back(8'hCC);
      end
      got = bus.rsp_valid;
    end
    if (!got) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    chk("latency", 64'(n), 64'(e_lat));
    chk("rsp_hit", 64'(bus.rsp_hit), 64'(e_hit));
    chk("rsp_msg_idx", 64'(bus.rsp_msg_idx), 64'(e_idx));
    chk("rsp_meta", 64'(bus.rsp_meta), 64'(e_meta));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_fields", {39'd0, bus.rsp_hit, bus.rsp_msg_idx, bus.rsp_meta}, {39'd0, e_hit, e_idx, e_meta});
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    if (!e_hit) m_miss++;
    chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    chk("req_ready_gap", 64'(bus.req_ready), 64'd0);
  endtask

  task automatic model_lookup(input logic [7:0] id, input int hold, input bit disturb);
    bit e_hit; logic [1:0] e_idx; logic [21:0] e_meta; int e_lat;
    m_lookup(id, e_hit, e_idx, e_meta, e_lat);
    do_lookup(id, e_hit, e_idx, e_meta, e_lat, hold, disturb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] canon [3];
    logic [7:0] qids [6];
    logic [7:0] pp [3];
    logic [7:0] qid;
    bit         seen;
    int         np;

    canon = '{8'hAA, 8'hBB, 8'hCC};
    qids  = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h07, 8'h09};

    // np, p0, p1, p2, id, hit, idx, meta, lat
    vt[0] = '{2, 8'hAA, 8'hBB, 8'h00, 8'h02, 1, 2'd1, 22'h123402, 4};
    vt[1] = '{1, 8'hAA, 8'h00, 8'h00, 8'h09, 0, 2'd0, 22'h000000, 5};
    vt[2] = '{3, 8'hAA, 8'hBB, 8'hCC, 8'h02, 1, 2'd2, 22'h3FFF02, 7};
    vt[3] = '{3, 8'hAA, 8'hBB, 8'hCC, 8'h09, 1, 2'd2, 22'h155509, 4};
    vt[4] = '{1, 8'hAA, 8'h00, 8'h00, 8'h07, 1, 2'd0, 22'h2F0007, 4};
    vt[5] = '{1, 8'hAA, 8'h00, 8'h00, 8'h00, 0, 2'd0, 22'h000000, 5};
    vt[6] = '{1, 8'hBB, 8'h00, 8'h00, 8'h02, 0, 2'd0, 22'h000000, 3};
    vt[7] = '{0, 8'h00, 8'h00, 8'h00, 8'h01, 0, 2'd0, 22'h000000, 3};
    vt[8] = '{2, 8'hAA, 8'hBB, 8'h00, 8'h05, 1, 2'd1, 22'h03AB05, 3};
    vt[9] = '{2, 8'hAA, 8'hBB, 8'h00, 8'h07, 0, 2'd1, 22'h000000, 6};

    rst_n = 1'b0;
    cfg_dep_we = 0; cfg_fld_we = 0; cfg_msg_idx = 0; cfg_fld_slot = 0;
    cfg_dep_data = 0; cfg_fld_data = 0;
    nest_push = 0; nest_pop = 0; nest_id = 0;
    bus.req_valid = 0; bus.req_field_id = 0; bus.rsp_ready = 0;
    m_reset();

    // Reset values
    #12;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_fields", {39'd0, bus.rsp_hit, bus.rsp_msg_idx, bus.rsp_meta}, 64'd0);
    chk("rst_depth", 64'(nest_depth), 64'd0);
    chk("rst_err", {62'd0, err_overflow, err_underflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("req_ready_pre_edge", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    chk("req_ready_post_edge", 64'(bus.req_ready), 64'd1);

    load_tables();

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      set_path(vt[i].np, vt[i].p0, vt[i].p1, vt[i].p2);
      do_lookup(vt[i].id, vt[i].hit, vt[i].idx, vt[i].meta, vt[i].lat, 0, 0);
    end

    // Overflow and underflow
    set_path(0, 8'h00, 8'h00, 8'h00);
    nest_op(1, 0, 8'hAA);
    nest_op(1, 0, 8'hBB);
    nest_op(1, 0, 8'hCC);
    nest_op(1, 0, 8'hDD);
    nest_op(0, 0, 8'h00);
    for (int i = 0; i < 4; i++) nest_op(0, 1, 8'h00);
    nest_op(0, 0, 8'h00);

    // Simultaneous push/pop: replace top, or plain push at depth 0
    set_path(2, 8'hAA, 8'hDD, 8'h00);
    nest_op(1, 1, 8'hBB);
    do_lookup(8'h02, 1, 2'd1, 22'h123402, 4, 0, 0);
    set_path(0, 8'h00, 8'h00, 8'h00);
    nest_op(1, 1, 8'hAA);
    do_lookup(8'h07, 1, 2'd0, 22'h2F0007, 4, 0, 0);

    // Stalled response with path change during the lookup
    set_path(2, 8'hAA, 8'hBB, 8'h00);
    do_lookup(8'h02, 1, 2'd1, 22'h123402, 4, 10, 1);
    chk("depth_after_disturb", 64'(nest_depth), 64'd3);

    // Reset while scanning field slots
    set_path(2, 8'hAA, 8'hBB, 8'h00);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_field_id = 8'h02;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_fields", {39'd0, bus.rsp_hit, bus.rsp_msg_idx, bus.rsp_meta}, 64'd0);
    chk("mid_rst_depth", 64'(nest_depth), 64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1;
    end
    bus.rsp_ready = 1'b0;
    chk("no_rsp_after_reset", 64'(seen), 64'd0);
    chk("tables_cleared_miss", 64'(dut.dep_tbl[2]), 64'd0);

    // Three misses then one hit
    load_tables();
    set_path(1, 8'hAA, 8'h00, 8'h00);
    model_lookup(8'h09, 0, 0);
    model_lookup(8'h00, 0, 0);
    set_path(0, 8'h00, 8'h00, 8'h00);
    model_lookup(8'h01, 0, 0);
    set_path(2, 8'hAA, 8'hBB, 8'h00);
    model_lookup(8'h02, 0, 0);
`ifdef PROTO_LOOKUP_MISS_CNT_EN
    chk("miss_cnt", 64'(miss_cnt), 64'd3);
`endif

    // Randomized lookups against the model
    for (int it = 0; it < 40; it++) begin
      np = $urandom_range(0, 3);
      for (int k = 0; k < 3; k++)
        pp[k] = ($urandom_range(0, 3) != 0) ? canon[k] : 8'($urandom_range(1, 255));
      set_path(np, pp[0], pp[1], pp[2]);
      if ($urandom_range(0, 3) == 0)
        cfg_fld($urandom_range(0, NUM_MSGS - 1), $urandom_range(0, MAX_FIELDS - 1),
                {14'($urandom), qids[$urandom_range(0, 5)]});
      qid = ($urandom_range(0, 5) != 0) ? qids[$urandom_range(0, 5)] : 8'($urandom);
      model_lookup(qid, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
`ifdef PROTO_LOOKUP_MISS_CNT_EN
    chk("miss_cnt_final", 64'(miss_cnt), 64'(m_miss));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
